mac_row_accumulator: RTL and testbench

//  Downstream consumer of the X buffer. Takes the four 8-bit X taps (X_reg1..X_reg4) plus four

---
 rtl/mac_row_accumulator.sv | 170 +++++++++++++++++
 tb/tb_mac_row_accumulator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_row_accumulator.sv
`default_nettype none
// mac_row_accumulator: 4-lane unsigned-x * signed-coef MAC, ACC_LEN beats per row, N_ROWS rows per frame. Rev 1.0
// Optional macro MAC_RELU_EN: negative row results are clamped to 0 before they are presented.
module mac_row_accumulator #(
  parameter int ACC_LEN = 3,
  parameter int N_ROWS  = 3,
  parameter int ACC_W   = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              x0,
  input  logic [7:0]              x1,
  input  logic [7:0]              x2,
  input  logic [7:0]              x3,
  input  logic [7:0]              c0,
  input  logic [7:0]              c1,
  input  logic [7:0]              c2,
  input  logic [7:0]              c3,
  output logic [7:0]              acc_counter,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [17:0]      psum_q, psum_d;
  logic                    psum_vld_q, psum_vld_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic [7:0]              acc_counter_q, acc_counter_d;
  logic signed [ACC_W-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    frame_done_q, frame_done_d;

  logic                    in_ready_w;
  logic                    accept_w;
  logic signed [17:0]      mac_w;
  logic signed [ACC_W-1:0] row_sum_w;
  logic signed [ACC_W-1:0] row_out_w;

  // x is zero-extended so that 255 stays positive in the signed product.
  function automatic logic signed [17:0] lane(input logic [7:0] x, input logic [7:0] c);
    logic signed [17:0] sx;
    logic signed [17:0] sc;
    sx = {10'd0, x};
    sc = {{10{c[7]}}, c};
    return sx * sc;
  endfunction

  assign mac_w      = lane(x0, c0) + lane(x1, c1) + lane(x2, c2) + lane(x3, c3);
  assign in_ready_w = (state_q == S_ACC) && (beat_cnt_q < CNT_W'(ACC_LEN));
  assign accept_w   = in_valid && in_ready_w;
  assign row_sum_w  = acc_q + ACC_W'(psum_q);

`ifdef MAC_RELU_EN
  assign row_out_w = row_sum_w[ACC_W-1] ? '0 : row_sum_w;
`else
  assign row_out_w = row_sum_w;
`endif

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    psum_d         = psum_q;
    psum_vld_d     = 1'b0;
    beat_cnt_d     = beat_cnt_q;
    row_cnt_d      = row_cnt_q;
    acc_counter_d  = acc_counter_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    frame_done_d   = 1'b0;

    if (accept_w) begin
      psum_d     = mac_w;
      psum_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d         = '0;
          beat_cnt_d    = '0;
          row_cnt_d     = '0;
          acc_counter_d = '0;
          state_d       = S_ACC;
        end
      end
      S_ACC: begin
        if (accept_w) begin
          beat_cnt_d    = beat_cnt_q + 1'b1;
          acc_counter_d = acc_counter_q + 8'd1;
        end
        // Accepts stop once beat_cnt reaches ACC_LEN, so a pending psum then is the row's last.
        if (psum_vld_q) begin
          if (beat_cnt_q == CNT_W'(ACC_LEN)) begin
            result_d       = row_out_w;
            result_valid_d = 1'b1;
            acc_d          = '0;
            beat_cnt_d     = '0;
            state_d        = S_HOLD;
          end else begin
            acc_d = row_sum_w;
          end
        end
      end
      S_HOLD: begin
        if (result_valid_q && result_ready) begin
          result_valid_d = 1'b0;
          row_cnt_d      = row_cnt_q + 1'b1;
          if (row_cnt_q == CNT_W'(N_ROWS - 1)) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      psum_q         <= '0;
      psum_vld_q     <= 1'b0;
      beat_cnt_q     <= '0;
      row_cnt_q      <= '0;
      acc_counter_q  <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      psum_q         <= psum_d;
      psum_vld_q     <= psum_vld_d;
      beat_cnt_q     <= beat_cnt_d;
      row_cnt_q      <= row_cnt_d;
      acc_counter_q  <= acc_counter_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign in_ready     = in_ready_w;
  assign acc_counter  = acc_counter_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_row_accumulator.sv
`default_nettype none
// tb_mac_row_accumulator: table vectors, hand-written corner sequences and random frames vs. a dot-product model.
module tb_mac_row_accumulator;
  localparam int ACC_LEN = 3;
  localparam int N_ROWS  = 3;
  localparam int ACC_W   = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic result_ready = 1'b0;
  logic [7:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic [7:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0;
  logic in_ready, result_valid, frame_done, busy;
  logic [7:0] acc_counter;
  logic signed [ACC_W-1:0] result;

  int errors = 0;
  int checks = 0;

  mac_row_accumulator #(.ACC_LEN(ACC_LEN), .N_ROWS(N_ROWS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .acc_counter(acc_counter), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int dot(input logic [31:0] x, input logic [31:0] c);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] xb;
      logic signed [7:0] cb;
      xb = x[8*i +: 8];
      cb = c[8*i +: 8];
      s += int'(xb) * int'(cb);
    end
    return s;
  endfunction

  // Reference model: running row sum and queue of expected row results.
  int model_q[$];
  int model_sum = 0;
  int model_beats = 0;

  task automatic model_clear();
    model_q.delete();
    model_sum = 0;
    model_beats = 0;
  endtask

  task automatic send_beat(input logic [31:0] x, input logic [31:0] c, input int gap);
    bit accepted = 0;
    repeat (gap) step();
    {x3, x2, x1, x0} = x;
    {c3, c2, c1, c0} = c;
    in_valid = 1'b1;
    for (int t = 0; t < 64 && !accepted; t++) begin
      if (in_ready) begin
        accepted = 1;
        model_sum += dot(x, c);
        model_beats++;
        if (model_beats == ACC_LEN) begin
          model_q.push_back(relu(model_sum));
          model_sum = 0;
          model_beats = 0;
        end
      end
      step();
    end
    in_valid = 1'b0;
    if (!accepted) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic take_result(input string name, input int exp, input int stall);
    int t = 0;
    logic signed [ACC_W-1:0] held;
    while (!result_valid && t < 64) begin
      step();
      t++;
    end
    if (!result_valid) begin
      check({name, "_valid_timeout"}, 0, 1);
    end else begin
      check(name, int'(result), exp);
      held = result;
      repeat (stall) begin
        step();
        check({name, "_hold_valid"}, result_valid, 1);
        check({name, "_hold_stable"}, int'(result), int'(held));
        check({name, "_hold_in_ready"}, in_ready, 0);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      check({name, "_valid_clear"}, result_valid, 0);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_acc_counter", acc_counter, 0);
    check("start_in_ready", in_ready, 1);
  endtask

  task automatic frame_end_checks();
    check("frame_done_pulse", frame_done, 1);
    check("busy_fall", busy, 0);
    check("frame_acc_counter", acc_counter, ACC_LEN * N_ROWS);
    step();
    check("frame_done_single", frame_done, 0);
  endtask

  task automatic send_row(input logic [31:0] x, input logic [31:0] c, input int gap);
    for (int b = 0; b < ACC_LEN; b++) send_beat(x, c, gap);
    check("no_early_valid", result_valid, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_result_valid"}, result_valid, 0);
    check({name, "_frame_done"}, frame_done, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_result"}, int'(result), 0);
    check({name, "_acc_counter"}, acc_counter, 0);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] c;
    int          raw;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{x: {8'd4, 8'd3, 8'd2, 8'd1},       c: {8'd1, 8'd1, 8'd1, 8'd1},       raw: 30};
    tbl[1] = '{x: {4{8'd255}},                     c: {4{8'h80}},                     raw: -391680};
    tbl[2] = '{x: {4{8'd255}},                     c: {4{8'd127}},                    raw: 388620};
    tbl[3] = '{x: {8'd40, 8'd30, 8'd20, 8'd10},   c: {8'hFE, 8'd2, 8'hFF, 8'd1},     raw: -90};
    tbl[4] = '{x: 32'd0,                           c: {8'h9C, 8'd7, 8'h81, 8'd55},    raw: 0};
    tbl[5] = '{x: {8'd0, 8'd0, 8'd0, 8'd100},     c: {8'd5, 8'd5, 8'd5, 8'd5},       raw: 1500};

    step();
    step();
    check_all_zero("reset");
    rst = 1'b1;
    step();

    // Table-driven frames: two frames of three rows, gap between beats grows per row.
    for (int f = 0; f < 2; f++) begin
      start_frame();
      for (int r = 0; r < N_ROWS; r++) begin
        send_row(tbl[f*N_ROWS + r].x, tbl[f*N_ROWS + r].c, r);
        take_result("tbl_result", relu(tbl[f*N_ROWS + r].raw), 0);
        check("tbl_acc_counter", acc_counter, ACC_LEN * (r + 1));
      end
      frame_end_checks();
    end

    // Stalled consumer: beats offered during HOLD are dropped; start in ACC is ignored.
    start_frame();
    send_row(tbl[0].x, tbl[0].c, 0);
    for (int t = 0; t < 8 && !result_valid; t++) step();
    check("stall_valid", result_valid, 1);
    {x3, x2, x1, x0} = tbl[2].x;
    {c3, c2, c1, c0} = tbl[2].c;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_result", int'(result), relu(30));
      step();
    end
    in_valid = 1'b0;
    check("stall_still_valid", result_valid, 1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("stall_valid_clear", result_valid, 0);
    check("stall_dropped_beats", acc_counter, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_acc_counter", acc_counter, 3);
    check("start_in_acc_busy", busy, 1);
    send_row(tbl[2].x, tbl[2].c, 1);
    take_result("stall_row2", relu(388620), 2);
    send_row(tbl[5].x, tbl[5].c, 0);
    take_result("stall_row3", relu(1500), 0);
    frame_end_checks();

    // Reset in the middle of accumulation.
    start_frame();
    send_beat(tbl[5].x, tbl[5].c, 0);
    send_beat(tbl[5].x, tbl[5].c, 0);
    rst = 1'b0;
    step();
    check_all_zero("midreset");
    rst = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midreset_no_valid", result_valid, 0);
      check("midreset_idle_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    model_clear();

    // Random frames against the model.
    for (int f = 0; f < 4; f++) begin
      start_frame();
      for (int r = 0; r < N_ROWS; r++) begin
        for (int b = 0; b < ACC_LEN; b++)
          send_beat($urandom, $urandom, $urandom_range(0, 2));
        if (model_q.size() == 0) begin
          check("model_queue_empty", 0, 1);
        end else begin
          take_result("rand_result", model_q.pop_front(), $urandom_range(0, 3));
        end
        check("rand_acc_counter", acc_counter, ACC_LEN * (r + 1));
      end
      frame_end_checks();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
